// File: rtl/sensor_ram_sched.sv
// sensor_ram_sched: arbitrates sensor frame bursts and host byte reads onto one RAM port
module sensor_ram_sched #(
    parameter logic [7:0] BANK1_BASE = 8'h10,
    parameter logic [7:0] STAT_ADDR  = 8'h20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         frame_req_i,
    input  logic [111:0] frame_data_i,
    output logic         frame_ack_o,
    output logic         frame_done_o,
    input  logic         host_req_i,
    input  logic [7:0]   host_addr_i,
    output logic         host_ack_o,
    output logic [7:0]   host_rdata_o,
    output logic [7:0]   ram_addr_o,
    output logic [7:0]   ram_wdata_o,
    output logic         ram_en_o,
    output logic         ram_wen_o,
    input  logic [7:0]   ram_rdata_i
);
    typedef enum logic [1:0] {IDLE, WR, RD_ADDR, RD_CAP} state_t;

    state_t         state_q, state_d;
    logic           bank_q, bank_d;
    logic [7:0]     seq_q, seq_d;
    logic           last_frame_q, last_frame_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [111:0]   frame_q, frame_d;
    logic [7:0]     ram_addr_q, ram_addr_d;
    logic [7:0]     ram_wdata_q, ram_wdata_d;
    logic           ram_en_q, ram_en_d;
    logic           ram_wen_q, ram_wen_d;
    logic           done_q, done_d;
    logic [7:0]     rdata_q, rdata_d;
    logic           grant_f, grant_h;

    // Address and data of burst beat j: 16 frame-area bytes, then sequence and bank bytes
    function automatic logic [15:0] beat(input logic [4:0] j, input logic [111:0] f,
                                         input logic b, input logic [7:0] s);
        logic [7:0] base;
        base = b ? BANK1_BASE : 8'h00;
        if (j < 5'd16)
            beat = {base + {3'b000, j}, (j < 5'd14) ? f[{j, 3'b000} +: 8] : 8'h00};
        else
            beat = {STAT_ADDR + {7'b0, j[0]}, j[0] ? {7'b0, b} : s + 8'd1};
    endfunction

    // Frame wins on contention unless it was the last one served; nothing is granted in reset
    assign grant_f = rst_n && state_q == IDLE && frame_req_i && (!host_req_i || !last_frame_q);
    assign grant_h = rst_n && state_q == IDLE && host_req_i && !grant_f;

    assign frame_ack_o  = grant_f;
    assign frame_done_o = done_q;
    assign host_ack_o   = state_q == RD_CAP;
    assign host_rdata_o = host_ack_o ? ram_rdata_i : rdata_q;
    assign ram_addr_o   = ram_addr_q;
    assign ram_wdata_o  = ram_wdata_q;
    assign ram_en_o     = ram_en_q;
    assign ram_wen_o    = ram_wen_q;

    // Next-state logic; RAM controls are registered one cycle ahead of the beat they drive
    always_comb begin
        state_d      = state_q;
        bank_d       = bank_q;
        seq_d        = seq_q;
        last_frame_d = last_frame_q;
        cnt_d        = cnt_q;
        frame_d      = frame_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        ram_en_d     = 1'b0;
        ram_wen_d    = 1'b0;
        done_d       = 1'b0;
        rdata_d      = rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_f) begin
                    frame_d                   = frame_data_i;
                    cnt_d                     = 5'd0;
                    {ram_addr_d, ram_wdata_d} = beat(5'd0, frame_data_i, bank_q, seq_q);
                    ram_en_d                  = 1'b1;
                    ram_wen_d                 = 1'b1;
                    last_frame_d              = 1'b1;
                    state_d                   = WR;
                end else if (grant_h) begin
                    ram_addr_d   = host_addr_i;
                    ram_en_d     = 1'b1;
                    last_frame_d = 1'b0;
                    state_d      = RD_ADDR;
                end
            end
            WR: begin
                if (cnt_q == 5'd17) begin
                    done_d  = 1'b1;
                    seq_d   = seq_q + 8'd1;
                    bank_d  = ~bank_q;
                    state_d = IDLE;
                end else begin
                    cnt_d                     = cnt_q + 5'd1;
                    {ram_addr_d, ram_wdata_d} = beat(cnt_q + 5'd1, frame_q, bank_q, seq_q);
                    ram_en_d                  = 1'b1;
                    ram_wen_d                 = 1'b1;
                end
            end
            RD_ADDR: state_d = RD_CAP;
            RD_CAP: begin
                rdata_d = ram_rdata_i;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any transaction at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bank_q       <= 1'b0;
            seq_q        <= 8'h00;
            last_frame_q <= 1'b0;
            cnt_q        <= 5'd0;
            frame_q      <= '0;
            ram_addr_q   <= 8'h00;
            ram_wdata_q  <= 8'h00;
            ram_en_q     <= 1'b0;
            ram_wen_q    <= 1'b0;
            done_q       <= 1'b0;
            rdata_q      <= 8'h00;
        end else begin
            state_q      <= state_d;
            bank_q       <= bank_d;
            seq_q        <= seq_d;
            last_frame_q <= last_frame_d;
            cnt_q        <= cnt_d;
            frame_q      <= frame_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_en_q     <= ram_en_d;
            ram_wen_q    <= ram_wen_d;
            done_q       <= done_d;
            rdata_q      <= rdata_d;
        end
    end
endmodule

// File: tb/tb_sensor_ram_sched.sv
// tb_sensor_ram_sched: table-driven and scoreboard bench for sensor_ram_sched
module tb_sensor_ram_sched;
    logic         clk = 1'b0, rst_n = 1'b0, frame_req = 1'b0, host_req = 1'b0;
    logic [111:0] frame_data = '0;
    logic [7:0]   host_addr = 8'h00, ram_rdata = 8'h00;
    logic         frame_ack, frame_done, host_ack, ram_en, ram_wen;
    logic [7:0]   host_rdata, ram_addr, ram_wdata;

    sensor_ram_sched dut (
        .clk(clk), .rst_n(rst_n),
        .frame_req_i(frame_req), .frame_data_i(frame_data), .frame_ack_o(frame_ack),
        .frame_done_o(frame_done), .host_req_i(host_req), .host_addr_i(host_addr),
        .host_ack_o(host_ack), .host_rdata_o(host_rdata), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_en_o(ram_en), .ram_wen_o(ram_wen),
        .ram_rdata_i(ram_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM with one-cycle read latency
    logic [7:0] mem [256];
    always @(posedge clk)
        if (ram_en) begin
            if (ram_wen) mem[ram_addr] <= ram_wdata;
            else ram_rdata <= mem[ram_addr];
        end

    int total = 0, bad = 0;
    task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    // Scoreboard of expected {addr, data} writes
    logic [15:0] wq[$];
    always @(negedge clk)
        if (ram_en && ram_wen) begin
            if (wq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got %0h:%0h expected none", ram_addr, ram_wdata);
            end else check("ram_write", {16'h0, ram_addr, ram_wdata}, {16'h0, wq.pop_front()});
        end

    logic [7:0] m_seq = 8'h00;
    logic       m_bank = 1'b0;
    logic [7:0] exp_mem [256];

    task automatic push_frame(input logic [111:0] d);
        logic [7:0] base, b;
        base = m_bank ? 8'h10 : 8'h00;
        for (int i = 0; i < 16; i++) begin
            b = (i < 14) ? d[8*i +: 8] : 8'h00;
            wq.push_back({base + 8'(i), b});
            exp_mem[base + 8'(i)] = b;
        end
        m_seq = m_seq + 8'd1;
        wq.push_back({8'h20, m_seq});
        wq.push_back({8'h21, 7'b0, m_bank});
        exp_mem[8'h20] = m_seq;
        exp_mem[8'h21] = {7'b0, m_bank};
        m_bank = ~m_bank;
    endtask

    task automatic wait_done(input int t);
        int n = 0;
        while (!frame_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("done_time", 32'(cyc - t), 19);
        check("writes_left", 32'(wq.size()), 0);
    endtask

    task automatic do_frame(input logic [111:0] d);
        int t;
        push_frame(d);
        @(negedge clk);
        frame_req = 1'b1;
        frame_data = d;
        #1 check("frame_ack", {31'b0, frame_ack}, 1);
        t = cyc;
        @(negedge clk);
        frame_req = 1'b0;
        wait_done(t);
    endtask

    task automatic wait_host(input int h, input logic [7:0] e);
        int n = 0;
        while (!host_ack && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("rd_time", 32'(cyc - h), 2);
        check("rd_data", {24'h0, host_rdata}, {24'h0, e});
        host_req = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] e);
        int h;
        @(negedge clk);
        host_req = 1'b1;
        host_addr = a;
        h = cyc;
        @(negedge clk);
        check("rd_ram", {22'h0, ram_en, ram_wen, ram_addr}, {22'h0, 2'b10, a});
        wait_host(h, e);
        @(negedge clk);
        check("rd_hold", {23'h0, host_ack, host_rdata}, {23'h0, 1'b0, e});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        frame_req = 1'b1;
        host_req = 1'b1;
        #1;
        check("rst_acks", {29'h0, frame_ack, frame_done, host_ack}, 0);
        check("rst_ram", {14'h0, ram_en, ram_wen, ram_addr, ram_wdata}, 0);
        check("rst_rdata", {24'h0, host_rdata}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        frame_req = 1'b0;
        host_req = 1'b0;
        m_seq = 8'h00;
        m_bank = 1'b0;
        wq.delete();
    endtask

    typedef struct {
        logic         rd;
        logic [111:0] d;
        logic [7:0]   a;
        logic [7:0]   e;
    } vec_t;

    localparam logic [111:0] D1 = 112'h0D0E_0B0C_090A_0708_0506_0304_0102;
    localparam logic [111:0] D2 = 112'hA656_A555_A454_A353_A252_A151_A050;

    vec_t tv [15];
    initial begin
        int t, h, nd;
        logic [111:0] d;
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int t, h, nd;
        logic [111:0] d;
        tv[0]  = '{1'b0, D1, 8'h00, 8'h00};
        tv[1]  = '{1'b1, '0, 8'h21, 8'h00};
        tv[2]  = '{1'b1, '0, 8'h20, 8'h01};
        tv[3]  = '{1'b1, '0, 8'h00, 8'h02};
        tv[4]  = '{1'b1, '0, 8'h0D, 8'h0D};
        tv[5]  = '{1'b1, '0, 8'h0C, 8'h0E};
        tv[6]  = '{1'b1, '0, 8'h05, 8'h05};
        tv[7]  = '{1'b1, '0, 8'h0E, 8'h00};
        tv[8]  = '{1'b0, D2, 8'h00, 8'h00};
        tv[9]  = '{1'b1, '0, 8'h10, 8'h50};
        tv[10] = '{1'b1, '0, 8'h11, 8'hA0};
        tv[11] = '{1'b1, '0, 8'h1D, 8'hA6};
        tv[12] = '{1'b1, '0, 8'h20, 8'h02};
        tv[13] = '{1'b1, '0, 8'h21, 8'h01};
        tv[14] = '{1'b1, '0, 8'h00, 8'h02};

        do_reset();
        for (int i = 0; i < 15; i++)
            if (tv[i].rd) do_read(tv[i].a, tv[i].e);
            else do_frame(tv[i].d);

        // Simultaneous requests after reset: frame first, then host, then frame again
        do_reset();
        for (int r = 0; r < 2; r++) begin
            push_frame(r == 0 ? D1 : D2);
            @(negedge clk);
            frame_req = 1'b1;
            host_req = 1'b1;
            host_addr = 8'h20 + 8'(r);
            frame_data = r == 0 ? D1 : D2;
            #1 check("sim_frame_first", {31'b0, frame_ack}, 1);
            t = cyc;
            @(negedge clk);
            frame_req = 1'b0;
            wait_done(t);
            h = cyc;
            wait_host(h, r == 0 ? 8'h01 : 8'h01);
        end

        // After a frame is served last, the host wins the next contention
        do_frame(D1);
        push_frame(D2);
        @(negedge clk);
        frame_req = 1'b1;
        host_req = 1'b1;
        host_addr = 8'h21;
        frame_data = D2;
        #1 check("prio_host_wins", {31'b0, frame_ack}, 0);
        h = cyc;
        @(negedge clk);
        wait_host(h, 8'h00);
        @(negedge clk);
        #1 check("prio_frame_next", {31'b0, frame_ack}, 1);
        t = cyc;
        @(negedge clk);
        frame_req = 1'b0;
        wait_done(t);

        // Sequence number wraps after 256 frames
        do_reset();
        for (int i = 0; i < 256; i++) begin
            d = {16'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
            do_frame(d);
        end
        do_read(8'h20, 8'h00);
        do_read(8'h21, 8'h01);

        // Reset during beat 7 aborts the burst
        do_reset();
        push_frame(D2);
        @(negedge clk);
        frame_req = 1'b1;
        frame_data = D2;
        @(negedge clk);
        frame_req = 1'b0;
        repeat (7) @(negedge clk);
        check("abort_beat7", {24'h0, ram_addr}, 8'h07);
        rst_n = 1'b0;
        #1 check("abort_ram_en", {31'b0, ram_en}, 0);
        wq.delete();
        m_seq = 8'h00;
        m_bank = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (25) begin
            @(negedge clk);
            nd += int'(frame_done);
        end
        check("abort_no_done", 32'(nd), 0);
        do_frame(D1);
        do_read(8'h20, 8'h01);
        do_read(8'h21, 8'h00);
        do_read(8'h01, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
